// File: rtl/sm_dbg_pkg.sv
// rtl/sm_dbg_pkg.sv - shared state encoding, register indices and default widths for sm_dbg_ctrl
package sm_dbg_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;
    localparam int STEP_W_DEF = 16;
    localparam int REG_PC     = 0;
    localparam int REG_LAST   = 31;

    typedef enum logic [2:0] {
        ST_HALT      = 3'd0,
        ST_RUN       = 3'd1,
        ST_STEP      = 3'd2,
        ST_DUMP_ADDR = 3'd3,
        ST_DUMP_WAIT = 3'd4
    } state_t;

    function automatic logic is_exec(input state_t s);
        return (s == ST_RUN) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/sm_dbg_bp_match.sv
// rtl/sm_dbg_bp_match.sv - PC breakpoint comparator with one-shot skip so a resume executes the bp instruction
module sm_dbg_bp_match #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_arm,
    input  logic              i_active,
    input  logic              i_cpu_en,
    input  logic [DATA_W-1:0] i_reg_data,
    input  logic [DATA_W-1:0] i_bp_addr,
    input  logic              i_bp_en,
    output logic              o_match
);

    logic r_skip;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_skip <= 1'b0;
        end else if (i_arm) begin
            r_skip <= 1'b1;
        end else if (i_active && i_cpu_en) begin
            r_skip <= 1'b0;
        end
    end

    assign o_match = i_bp_en && i_active && !r_skip && (i_reg_data == i_bp_addr);

endmodule

// File: rtl/sm_dbg_ctrl.sv
// rtl/sm_dbg_ctrl.sv - sm_cpu run/halt/step sequencer with PC breakpoint and register-file dump stream
// Optional breakpoint logic is compiled in with SM_DBG_BREAKPOINT_EN.
module sm_dbg_ctrl
    import sm_dbg_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int STEP_W = STEP_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_run,
    input  logic              i_cmd_halt,
    input  logic              i_cmd_step,
    input  logic [STEP_W-1:0] i_step_n,
    input  logic              i_cmd_dump,
    input  logic [DATA_W-1:0] i_bp_addr,
    input  logic              i_bp_en,
    output logic [ADDR_W-1:0] o_reg_addr,
    input  logic [DATA_W-1:0] i_reg_data,
    output logic              o_cpu_en,
    output logic              o_halted,
    output logic              o_bp_hit,
    output logic              o_dump_valid,
    input  logic              i_dump_ready,
    output logic [ADDR_W-1:0] o_dump_idx,
    output logic [DATA_W-1:0] o_dump_data,
    output logic              o_dump_done
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_reg_addr;
    logic              r_halted;
    logic              r_bp_hit;
    logic              r_dump_valid;
    logic [ADDR_W-1:0] r_dump_idx;
    logic [DATA_W-1:0] r_dump_data;
    logic              r_dump_done;
    logic [STEP_W-1:0] r_step_cnt;

    logic w_exec;
    logic w_bp_match;
    logic w_start_exec;

    assign w_exec       = is_exec(r_state);
    // A command is only launched from HALT, and halt outranks everything else.
    assign w_start_exec = (r_state == ST_HALT) && !i_cmd_halt && !i_cmd_dump
                          && (i_cmd_step || i_cmd_run);

`ifdef SM_DBG_BREAKPOINT_EN
    sm_dbg_bp_match #(
        .DATA_W (DATA_W)
    ) u_bp_match (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_arm      (w_start_exec),
        .i_active   (w_exec),
        .i_cpu_en   (o_cpu_en),
        .i_reg_data (i_reg_data),
        .i_bp_addr  (i_bp_addr),
        .i_bp_en    (i_bp_en),
        .o_match    (w_bp_match)
    );
`else
    logic w_unused_bp;
    assign w_unused_bp = ^{i_bp_addr, i_bp_en, w_start_exec};
    assign w_bp_match  = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_HALT;
            r_reg_addr   <= ADDR_W'(REG_PC);
            r_halted     <= 1'b1;
            r_bp_hit     <= 1'b0;
            r_dump_valid <= 1'b0;
            r_dump_idx   <= '0;
            r_dump_data  <= '0;
            r_dump_done  <= 1'b0;
            r_step_cnt   <= '0;
        end else begin
            r_dump_done <= 1'b0;
            case (r_state)
                ST_HALT: begin
                    if (i_cmd_halt) begin
                        r_state <= ST_HALT;
                    end else if (i_cmd_dump) begin
                        r_state    <= ST_DUMP_ADDR;
                        r_reg_addr <= ADDR_W'(REG_PC);
                        r_halted   <= 1'b0;
                    end else if (i_cmd_step) begin
                        r_state    <= ST_STEP;
                        r_step_cnt <= (i_step_n == '0) ? STEP_W'(1) : i_step_n;
                        r_reg_addr <= ADDR_W'(REG_PC);
                        r_halted   <= 1'b0;
                        r_bp_hit   <= 1'b0;
                    end else if (i_cmd_run) begin
                        r_state    <= ST_RUN;
                        r_reg_addr <= ADDR_W'(REG_PC);
                        r_halted   <= 1'b0;
                        r_bp_hit   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (i_cmd_halt) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end else if (w_bp_match) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                        r_bp_hit <= 1'b1;
                    end
                end
                ST_STEP: begin
                    if (i_cmd_halt) begin
                        r_state    <= ST_HALT;
                        r_halted   <= 1'b1;
                        r_step_cnt <= '0;
                    end else if (w_bp_match) begin
                        r_state    <= ST_HALT;
                        r_halted   <= 1'b1;
                        r_bp_hit   <= 1'b1;
                        r_step_cnt <= '0;
                    end else begin
                        if (r_step_cnt != '0) begin
                            r_step_cnt <= r_step_cnt - STEP_W'(1);
                        end
                        if (r_step_cnt <= STEP_W'(1)) begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end
                    end
                end
                ST_DUMP_ADDR: begin
                    if (i_cmd_halt) begin
                        r_state    <= ST_HALT;
                        r_halted   <= 1'b1;
                        r_reg_addr <= ADDR_W'(REG_PC);
                    end else begin
                        r_state      <= ST_DUMP_WAIT;
                        r_dump_data  <= i_reg_data;
                        r_dump_idx   <= r_reg_addr;
                        r_dump_valid <= 1'b1;
                    end
                end
                ST_DUMP_WAIT: begin
                    if (i_cmd_halt) begin
                        r_state      <= ST_HALT;
                        r_halted     <= 1'b1;
                        r_dump_valid <= 1'b0;
                        r_reg_addr   <= ADDR_W'(REG_PC);
                    end else if (i_dump_ready) begin
                        r_dump_valid <= 1'b0;
                        if (r_reg_addr == ADDR_W'(REG_LAST)) begin
                            r_state     <= ST_HALT;
                            r_halted    <= 1'b1;
                            r_dump_done <= 1'b1;
                            r_reg_addr  <= ADDR_W'(REG_PC);
                        end else begin
                            r_state    <= ST_DUMP_ADDR;
                            r_reg_addr <= r_reg_addr + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    r_state  <= ST_HALT;
                    r_halted <= 1'b1;
                end
            endcase
        end
    end

    // The CPU is held on the matching edge so the breakpoint instruction stays unexecuted.
    assign o_cpu_en     = w_exec && !w_bp_match;
    assign o_reg_addr   = r_reg_addr;
    assign o_halted     = r_halted;
    assign o_bp_hit     = r_bp_hit;
    assign o_dump_valid = r_dump_valid;
    assign o_dump_idx   = r_dump_idx;
    assign o_dump_data  = r_dump_data;
    assign o_dump_done  = r_dump_done;

endmodule

// File: tb/tb_sm_dbg_ctrl.sv
// tb/tb_sm_dbg_ctrl.sv - self-checking bench for sm_dbg_ctrl with a behavioural sm_cpu PC/register model
module tb_sm_dbg_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_run, cmd_halt, cmd_step, cmd_dump;
    logic [15:0] step_n;
    logic [31:0] bp_addr;
    logic        bp_en;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic        cpu_en, halted, bp_hit;
    logic        dump_valid, dump_ready, dump_done;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;

    logic [31:0] pc;
    logic [31:0] rf [32];
    logic [4:0]  q_idx [$];
    logic [31:0] q_data [$];
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    sm_dbg_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cmd_run    (cmd_run),
        .i_cmd_halt   (cmd_halt),
        .i_cmd_step   (cmd_step),
        .i_step_n     (step_n),
        .i_cmd_dump   (cmd_dump),
        .i_bp_addr    (bp_addr),
        .i_bp_en      (bp_en),
        .o_reg_addr   (reg_addr),
        .i_reg_data   (reg_data),
        .o_cpu_en     (cpu_en),
        .o_halted     (halted),
        .o_bp_hit     (bp_hit),
        .o_dump_valid (dump_valid),
        .i_dump_ready (dump_ready),
        .o_dump_idx   (dump_idx),
        .o_dump_data  (dump_data),
        .o_dump_done  (dump_done)
    );

    always @(posedge clk) begin
        if (rst) pc <= 32'd0;
        else if (cpu_en) pc <= pc + 32'd1;
    end
    assign reg_data = (reg_addr == 5'd0) ? pc : rf[reg_addr];

    task automatic send(input logic run, input logic hlt, input logic stp, input logic dmp,
                        input logic [15:0] n);
        cmd_run = run; cmd_halt = hlt; cmd_step = stp; cmd_dump = dmp; step_n = n;
        @(negedge clk);
        cmd_run = 0; cmd_halt = 0; cmd_step = 0; cmd_dump = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_total++; if (halted !== 1'b1) $display("FAIL reset_halted c%0d: got %b want 1", c, halted); else n_pass++;
            n_total++; if (cpu_en !== 1'b0) $display("FAIL reset_cpu_en c%0d: got %b want 0", c, cpu_en); else n_pass++;
            n_total++; if (reg_addr !== 5'd0) $display("FAIL reset_reg_addr c%0d: got %0d want 0", c, reg_addr); else n_pass++;
            n_total++; if (dump_valid !== 1'b0) $display("FAIL reset_dump_valid c%0d: got %b want 0", c, dump_valid); else n_pass++;
        end
        n_total++; if (bp_hit !== 1'b0 || dump_done !== 1'b0) $display("FAIL reset_flags: got bp_hit=%b done=%b want 0/0", bp_hit, dump_done); else n_pass++;
        n_total++; if (dump_idx !== 5'd0 || dump_data !== 32'd0) $display("FAIL reset_dump_regs: got idx=%0d data=%0h want 0/0", dump_idx, dump_data); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_step(input logic [15:0] n, input int exp_cycles);
        logic [31:0] pc0;
        int cnt, cyc;
        pc0 = pc; cnt = 0; cyc = 0;
        send(0, 0, 1, 0, n);
        while (!halted && cyc < 100) begin
            if (cpu_en) cnt++;
            @(negedge clk); cyc++;
        end
        n_total++; if (cyc >= 100) $display("FAIL step%0d_timeout: got no halt within %0d cycles want halt", n, cyc); else n_pass++;
        n_total++; if (cnt != exp_cycles) $display("FAIL step%0d_cpu_en_cycles: got %0d want %0d", n, cnt, exp_cycles); else n_pass++;
        n_total++; if (pc !== pc0 + 32'(exp_cycles)) $display("FAIL step%0d_pc: got %0d want %0d", n, pc, pc0 + 32'(exp_cycles)); else n_pass++;
        n_total++; if (cpu_en !== 1'b0 || bp_hit !== 1'b0) $display("FAIL step%0d_after: got cpu_en=%b bp_hit=%b want 0/0", n, cpu_en, bp_hit); else n_pass++;
    endtask

    task automatic test_breakpoint();
        int cyc;
        logic seen_hold;
        bp_addr = 32'd8; bp_en = 1'b1; cyc = 0; seen_hold = 0;
        send(1, 0, 0, 0, 16'd0);
        while (!halted && cyc < 20) begin
            if (!cpu_en && reg_data == 32'd8) seen_hold = 1;
            @(negedge clk); cyc++;
        end
`ifdef SM_DBG_BREAKPOINT_EN
        n_total++; if (!halted) $display("FAIL bp_timeout: got no halt in %0d cycles want halt", cyc); else n_pass++;
        n_total++; if (!seen_hold) $display("FAIL bp_cpu_en_hold: got cpu_en never low at pc 8 want low"); else n_pass++;
        n_total++; if (pc !== 32'd8) $display("FAIL bp_pc: got %0d want 8", pc); else n_pass++;
        n_total++; if (bp_hit !== 1'b1) $display("FAIL bp_hit_set: got %b want 1", bp_hit); else n_pass++;
        send(0, 0, 1, 0, 16'd1);
        cyc = 0;
        while (!halted && cyc < 20) begin @(negedge clk); cyc++; end
        n_total++; if (pc !== 32'd9) $display("FAIL bp_resume_pc: got %0d want 9", pc); else n_pass++;
        n_total++; if (bp_hit !== 1'b0 || halted !== 1'b1) $display("FAIL bp_resume_flags: got bp_hit=%b halted=%b want 0/1", bp_hit, halted); else n_pass++;
`else
        n_total++; if (halted !== 1'b0) $display("FAIL nobp_still_running: got halted=%b want 0", halted); else n_pass++;
        n_total++; if (bp_hit !== 1'b0 || seen_hold) $display("FAIL nobp_no_hit: got bp_hit=%b hold=%b want 0/0", bp_hit, seen_hold); else n_pass++;
        send(0, 1, 0, 0, 16'd0);
        n_total++; if (halted !== 1'b1 || cpu_en !== 1'b0) $display("FAIL nobp_halt: got halted=%b cpu_en=%b want 1/0", halted, cpu_en); else n_pass++;
`endif
        bp_en = 1'b0;
    endtask

    task automatic test_run_halt();
        logic [31:0] pc0;
        int cnt;
        pc0 = pc; cnt = 0;
        send(1, 0, 0, 0, 16'd0);
        for (int i = 0; i < 7; i++) begin
            if (cpu_en) cnt++;
            @(negedge clk);
        end
        if (cpu_en) cnt++;
        send(0, 1, 0, 0, 16'd0);
        n_total++; if (cnt != 8) $display("FAIL run_cpu_en_cycles: got %0d want 8", cnt); else n_pass++;
        n_total++; if (pc !== pc0 + 32'd8) $display("FAIL run_pc: got %0d want %0d", pc, pc0 + 32'd8); else n_pass++;
        n_total++; if (halted !== 1'b1 || cpu_en !== 1'b0) $display("FAIL run_halted: got halted=%b cpu_en=%b want 1/0", halted, cpu_en); else n_pass++;
    endtask

    task automatic test_dump(input int mode, input int halt_at);
        int cyc, accepted, done_cnt;
        logic stall, aborted;
        logic [4:0]  h_idx, e_idx;
        logic [31:0] h_data, e_data;
        q_idx.delete(); q_data.delete();
        for (int i = 0; i < 32; i++) begin
            q_idx.push_back(5'(i));
            q_data.push_back((i == 0) ? pc : rf[i]);
        end
        dump_ready = 1'b0;
        send(0, 0, 0, 1, 16'd0);
        cyc = 0; accepted = 0; done_cnt = 0; stall = 0; aborted = 0; h_idx = 0; h_data = 0;
        while (!halted && cyc < 600) begin
            dump_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            if (cpu_en) begin
                n_total++; $display("FAIL dump_cpu_en: got 1 want 0 at cycle %0d", cyc);
            end
            if (dump_valid) begin
                if (stall) begin
                    n_total++; if (dump_idx !== h_idx || dump_data !== h_data) $display("FAIL dump_stable: got idx=%0d data=%0h want idx=%0d data=%0h", dump_idx, dump_data, h_idx, h_data); else n_pass++;
                end
                if (halt_at >= 0 && int'(dump_idx) == halt_at) begin
                    cmd_halt = 1'b1; dump_ready = 1'b0; aborted = 1'b1;
                end else if (dump_ready) begin
                    if (q_idx.size() == 0) begin
                        n_total++; $display("FAIL dump_extra_word: got idx=%0d want none", dump_idx);
                    end else begin
                        e_idx = q_idx.pop_front(); e_data = q_data.pop_front();
                        n_total++; if (dump_idx !== e_idx || dump_data !== e_data) $display("FAIL dump_word: got idx=%0d data=%0h want idx=%0d data=%0h", dump_idx, dump_data, e_idx, e_data); else n_pass++;
                        accepted++;
                    end
                end
                stall = !dump_ready; h_idx = dump_idx; h_data = dump_data;
            end else begin
                stall = 1'b0;
            end
            if (dump_done) done_cnt++;
            @(negedge clk);
            cmd_halt = 1'b0; cyc++;
        end
        dump_ready = 1'b0;
        n_total++; if (cyc >= 600) $display("FAIL dump_timeout: got no halt in %0d cycles want halt", cyc); else n_pass++;
        if (dump_done) done_cnt++;
        n_total++; if (dump_valid !== 1'b0 || reg_addr !== 5'd0) $display("FAIL dump_end_state: got valid=%b reg_addr=%0d want 0/0", dump_valid, reg_addr); else n_pass++;
        @(negedge clk);
        if (dump_done) done_cnt++;
        n_total++; if (done_cnt != (aborted ? 0 : 1)) $display("FAIL dump_done_count: got %0d want %0d", done_cnt, aborted ? 0 : 1); else n_pass++;
        n_total++; if (accepted != ((halt_at >= 0) ? halt_at : 32)) $display("FAIL dump_accepted: got %0d want %0d", accepted, (halt_at >= 0) ? halt_at : 32); else n_pass++;
        n_total++; if (!aborted && q_idx.size() != 0) $display("FAIL dump_words_missing: got %0d left want 0", q_idx.size()); else n_pass++;
    endtask

    task automatic test_halt_run_same();
        logic [31:0] pc0;
        pc0 = pc;
        send(1, 1, 0, 0, 16'd0);
        n_total++; if (halted !== 1'b1 || cpu_en !== 1'b0) $display("FAIL halt_run_same: got halted=%b cpu_en=%b want 1/0", halted, cpu_en); else n_pass++;
        repeat (3) @(negedge clk);
        n_total++; if (pc !== pc0 || dump_done !== 1'b0) $display("FAIL halt_run_pc: got pc=%0d done=%b want %0d/0", pc, dump_done, pc0); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0107;
        rst = 1'b1; cmd_run = 0; cmd_halt = 0; cmd_step = 0; cmd_dump = 0;
        step_n = 0; bp_addr = 0; bp_en = 0; dump_ready = 0;
        test_reset();
        test_step(16'd5, 5);
        test_step(16'd0, 1);
        test_breakpoint();
        test_run_halt();
        test_dump(0, -1);
        test_dump(1, -1);
        test_dump(1, 10);
        test_halt_run_same();
        test_dump(0, -1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
